// File: rtl/sha1_pad_if.sv
// sha1_pad_if: bus between the SHA-1 message padder, its host and the sha1 core.
//   Host side : iStart, iValid, iDat[31:0] (big-endian), iLast, iLastBytes[1:0] -> padder
//               oAck <- padder (word taken when iValid & oAck)
//   Core side : iCoreReady (core oReady) -> padder
//               oCoreDat[31:0], oCoreValid, oCoreInitial -> core iDat/iValid/iInitial
//               oDone <- padder (one-cycle pulse, digest valid on core oDat)
//   With SHA1_PAD_CNT_EN defined the bus also carries oBlocks[15:0], the number
//   of blocks sent for the current message.
// Modports: slave = the padder, master = host plus core environment.
`timescale 1ns/1ps
interface sha1_pad_if;
    logic        iStart;
    logic        iValid;
    logic [31:0] iDat;
    logic        iLast;
    logic [1:0]  iLastBytes;
    logic        oAck;
    logic        iCoreReady;
    logic [31:0] oCoreDat;
    logic        oCoreValid;
    logic        oCoreInitial;
    logic        oDone;
`ifdef SHA1_PAD_CNT_EN
    logic [15:0] oBlocks;

    modport slave (
        input  iStart, iValid, iDat, iLast, iLastBytes, iCoreReady,
        output oAck, oCoreDat, oCoreValid, oCoreInitial, oDone, oBlocks
    );
    modport master (
        output iStart, iValid, iDat, iLast, iLastBytes, iCoreReady,
        input  oAck, oCoreDat, oCoreValid, oCoreInitial, oDone, oBlocks
    );
`else
    modport slave (
        input  iStart, iValid, iDat, iLast, iLastBytes, iCoreReady,
        output oAck, oCoreDat, oCoreValid, oCoreInitial, oDone
    );
    modport master (
        output iStart, iValid, iDat, iLast, iLastBytes, iCoreReady,
        input  oAck, oCoreDat, oCoreValid, oCoreInitial, oDone
    );
`endif
endinterface

// File: rtl/sha1_pad.sv
// sha1_pad: FIPS 180 message padder and block sequencer in front of the sha1 core.
// Collects host words into a 16-word block buffer, appends 0x80 / zero fill /
// 64-bit bit length, and streams every block to the core in 16 back-to-back
// cycles once the core reports ready. oDone pulses after the final block.
// Ports: iClk, iRst (async, active-high), bus (sha1_pad_if.slave; see interface).
// Optional: define SHA1_PAD_CNT_EN to add bus.oBlocks, a saturating per-message
// count of blocks sent.
`timescale 1ns/1ps
module sha1_pad #(
    parameter int WORDSIZE = 32,
    parameter int WORDNUM  = 16,
    parameter int LENW     = 64
) (
    input  logic      iClk,
    input  logic      iRst,
    sha1_pad_if.slave bus
);
    localparam int IW     = $clog2(WORDNUM) + 1;
    localparam int LEN_HI = WORDNUM - 2;
    localparam int LEN_LO = WORDNUM - 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_PAD  = 3'd2,
        S_SEND = 3'd3,
        S_WAIT = 3'd4
    } state_t;

    // Keep the valid leading bytes of the final word and place 0x80 right after them.
    function automatic logic [WORDSIZE-1:0] close_word(input logic [WORDSIZE-1:0] dat,
                                                      input logic [1:0] nbytes);
        logic [WORDSIZE-1:0] w;
        case (nbytes)
            2'd1:    w = {dat[31:24], 8'h80, 16'h0000};
            2'd2:    w = {dat[31:16], 8'h80, 8'h00};
            2'd3:    w = {dat[31:8], 8'h80};
            default: w = dat;
        endcase
        return w;
    endfunction

    state_t                             state_q, state_d;
    logic [IW-1:0]                      idx_q, idx_d;
    logic [IW-1:0]                      pad_idx_q, pad_idx_d;   // word holding the 0x80 byte (16 = next block)
    logic [IW-2:0]                      snd_idx_q, snd_idx_d;
    logic [LENW-1:0]                    len_q, len_d;
    logic [WORDNUM-1:0][WORDSIZE-1:0]   buf_q, buf_d;
    logic                               firstblk_q, firstblk_d;
    logic                               more_q, more_d;
    logic                               last_blk_q, last_blk_d;
    logic                               lenblk_q, lenblk_d;     // a length-only block still has to go out
    logic                               snd_act_q, snd_act_d;
    logic                               busy_seen_q, busy_seen_d;
    logic                               ack_q, ack_d;
    logic [WORDSIZE-1:0]                cdat_q, cdat_d;
    logic                               cvalid_q, cvalid_d;
    logic                               cinit_q, cinit_d;
    logic                               done_q, done_d;
`ifdef SHA1_PAD_CNT_EN
    logic [15:0]                        blocks_q, blocks_d;
`endif

    logic                               acc_s;
    logic                               take_s;
    logic [IW-1:0]                      wr_idx_s;
    logic [LENW-1:0]                    len_base_s;
    logic [6:0]                         len_inc_s;

    assign acc_s      = bus.iValid && ack_q;
    assign take_s     = acc_s && ((state_q == S_FILL) || ((state_q == S_IDLE) && bus.iStart));
    assign wr_idx_s   = (state_q == S_IDLE) ? {IW{1'b0}} : idx_q;
    assign len_base_s = (state_q == S_IDLE) ? {LENW{1'b0}} : len_q;
    assign len_inc_s  = (bus.iLast && (bus.iLastBytes != 2'd0)) ? {2'b00, bus.iLastBytes, 3'b000} : 7'd32;

    // Next-state logic, block buffer updates and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pad_idx_d   = pad_idx_q;
        snd_idx_d   = snd_idx_q;
        len_d       = len_q;
        buf_d       = buf_q;
        firstblk_d  = firstblk_q;
        more_d      = more_q;
        last_blk_d  = last_blk_q;
        lenblk_d    = lenblk_q;
        snd_act_d   = snd_act_q;
        busy_seen_d = busy_seen_q;
        cdat_d      = {WORDSIZE{1'b0}};
        cvalid_d    = 1'b0;
        cinit_d     = 1'b0;
        done_d      = 1'b0;
`ifdef SHA1_PAD_CNT_EN
        blocks_d    = blocks_q;
`endif
        case (state_q)
            S_IDLE, S_FILL: begin
                if (take_s) begin
                    if (state_q == S_IDLE) begin
                        firstblk_d = 1'b1;
                        more_d     = 1'b0;
                        last_blk_d = 1'b0;
                        lenblk_d   = 1'b0;
`ifdef SHA1_PAD_CNT_EN
                        blocks_d   = 16'h0000;
`endif
                    end else begin
                        more_d     = 1'b0;
                    end
                    len_d = len_base_s + LENW'(len_inc_s);
                    if (bus.iLast) begin
                        buf_d[wr_idx_s[IW-2:0]] = close_word(bus.iDat, bus.iLastBytes);
                        if (bus.iLastBytes == 2'd0) begin
                            // A full last word pushes the pad byte into the following word,
                            // which may fall into the next block.
                            pad_idx_d = wr_idx_s + IW'(1);
                            if (wr_idx_s < IW'(LEN_LO)) begin
                                buf_d[wr_idx_s[IW-2:0] + (IW-1)'(1)] = 32'h8000_0000;
                            end else begin
                                buf_d = buf_d;
                            end
                        end else begin
                            pad_idx_d = wr_idx_s;
                        end
                        idx_d   = {IW{1'b0}};
                        state_d = S_PAD;
                    end else begin
                        buf_d[wr_idx_s[IW-2:0]] = bus.iDat;
                        idx_d = wr_idx_s + IW'(1);
                        if (wr_idx_s == IW'(LEN_LO)) begin
                            more_d    = 1'b1;
                            snd_act_d = 1'b0;
                            state_d   = S_SEND;
                        end else begin
                            state_d   = S_FILL;
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_PAD: begin
                if (lenblk_q) begin
                    buf_d    = '0;
                    buf_d[0] = (pad_idx_q == IW'(WORDNUM)) ? 32'h8000_0000 : 32'h0000_0000;
                    buf_d[LEN_HI] = len_q[LENW-1 -: WORDSIZE];
                    buf_d[LEN_LO] = len_q[WORDSIZE-1:0];
                    last_blk_d = 1'b1;
                    lenblk_d   = 1'b0;
                end else begin
                    for (int j = 0; j < LEN_HI; j++) begin
                        if (j > int'(pad_idx_q)) begin
                            buf_d[j] = 32'h0000_0000;
                        end else begin
                            buf_d[j] = buf_q[j];
                        end
                    end
                    if (int'(pad_idx_q) < LEN_HI) begin
                        buf_d[LEN_HI] = len_q[LENW-1 -: WORDSIZE];
                        buf_d[LEN_LO] = len_q[WORDSIZE-1:0];
                        last_blk_d    = 1'b1;
                    end else begin
                        // No room for the length: clear what follows the pad word and
                        // schedule an extra block carrying only the length.
                        for (int j = LEN_HI; j < WORDNUM; j++) begin
                            if (j > int'(pad_idx_q)) begin
                                buf_d[j] = 32'h0000_0000;
                            end else begin
                                buf_d[j] = buf_q[j];
                            end
                        end
                        lenblk_d = 1'b1;
                    end
                end
                snd_act_d = 1'b0;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (!snd_act_q) begin
                    if (bus.iCoreReady) begin
                        snd_act_d   = 1'b1;
                        snd_idx_d   = (IW-1)'(1);
                        busy_seen_d = 1'b0;
                        cdat_d      = buf_q[0];
                        cvalid_d    = 1'b1;
                        cinit_d     = firstblk_q;
`ifdef SHA1_PAD_CNT_EN
                        if (blocks_q != 16'hFFFF) begin
                            blocks_d = blocks_q + 16'd1;
                        end else begin
                            blocks_d = blocks_q;
                        end
`endif
                    end else begin
                        snd_act_d = 1'b0;
                    end
                end else begin
                    cdat_d      = buf_q[snd_idx_q];
                    cvalid_d    = 1'b1;
                    snd_idx_d   = snd_idx_q + (IW-1)'(1);
                    busy_seen_d = busy_seen_q | ~bus.iCoreReady;
                    if (snd_idx_q == (IW-1)'(LEN_LO)) begin
                        snd_act_d  = 1'b0;
                        firstblk_d = 1'b0;
                        state_d    = S_WAIT;
                    end else begin
                        state_d    = S_SEND;
                    end
                end
            end
            S_WAIT: begin
                // The core drops ready while it runs its rounds; the block is done
                // once ready comes back after having been seen low.
                if (!bus.iCoreReady) begin
                    busy_seen_d = 1'b1;
                end else if (busy_seen_q) begin
                    busy_seen_d = 1'b0;
                    if (lenblk_q) begin
                        state_d = S_PAD;
                    end else if (more_q) begin
                        idx_d   = {IW{1'b0}};
                        more_d  = 1'b0;
                        state_d = S_FILL;
                    end else begin
                        last_blk_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ack_d = (state_d == S_IDLE) || (state_d == S_FILL);
    end

    // State, buffer and output registers; reset discards any block in flight.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q     <= S_IDLE;
            idx_q       <= {IW{1'b0}};
            pad_idx_q   <= {IW{1'b0}};
            snd_idx_q   <= {(IW-1){1'b0}};
            len_q       <= {LENW{1'b0}};
            buf_q       <= '0;
            firstblk_q  <= 1'b0;
            more_q      <= 1'b0;
            last_blk_q  <= 1'b0;
            lenblk_q    <= 1'b0;
            snd_act_q   <= 1'b0;
            busy_seen_q <= 1'b0;
            ack_q       <= 1'b0;
            cdat_q      <= {WORDSIZE{1'b0}};
            cvalid_q    <= 1'b0;
            cinit_q     <= 1'b0;
            done_q      <= 1'b0;
`ifdef SHA1_PAD_CNT_EN
            blocks_q    <= 16'h0000;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pad_idx_q   <= pad_idx_d;
            snd_idx_q   <= snd_idx_d;
            len_q       <= len_d;
            buf_q       <= buf_d;
            firstblk_q  <= firstblk_d;
            more_q      <= more_d;
            last_blk_q  <= last_blk_d;
            lenblk_q    <= lenblk_d;
            snd_act_q   <= snd_act_d;
            busy_seen_q <= busy_seen_d;
            ack_q       <= ack_d;
            cdat_q      <= cdat_d;
            cvalid_q    <= cvalid_d;
            cinit_q     <= cinit_d;
            done_q      <= done_d;
`ifdef SHA1_PAD_CNT_EN
            blocks_q    <= blocks_d;
`endif
        end
    end

    assign bus.oAck         = ack_q;
    assign bus.oCoreDat     = cdat_q;
    assign bus.oCoreValid   = cvalid_q;
    assign bus.oCoreInitial = cinit_q;
    assign bus.oDone        = done_q;
`ifdef SHA1_PAD_CNT_EN
    assign bus.oBlocks      = blocks_q;
`endif
endmodule

// File: tb/tb_sha1_pad.sv
// tb_sha1_pad: drives byte messages into sha1_pad, emulates the core's ready
// behaviour, and compares every block word against FIPS 180 padding computed
// directly on the byte string.
`timescale 1ns/1ps
module tb_sha1_pad;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha1_pad_if bus ();
    sha1_pad dut (.iClk(clk), .iRst(rst), .bus(bus));

    int checks = 0;
    int passed = 0;

    // Core emulation and monitor state (written only by the negedge process).
    logic        core_rdy = 1'b1;
    logic        hold_rdy = 1'b0;
    int          core_cnt = 0;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    logic        gap_bad  = 1'b0;
    logic        ack_bad  = 1'b0;
    logic [31:0] cap_q[$];
    logic        cap_init_q[$];

    // Stimulus / reference state (written only by the initial block).
    logic [7:0]  msg_q[$];
    logic [31:0] exp_q[$];
    int          lens [6] = '{55, 56, 63, 64, 1, 120};

    assign bus.iCoreReady = core_rdy && !hold_rdy;

    // Core model: captures words, goes busy on the first word, returns ready later.
    always @(negedge clk) begin
        if (rst) begin
            core_cnt <= 0;
            busy_cnt <= 0;
            core_rdy <= 1'b1;
        end else begin
            if (bus.oCoreValid) begin
                cap_q.push_back(bus.oCoreDat);
                cap_init_q.push_back(bus.oCoreInitial);
                core_rdy <= 1'b0;
                if (bus.oAck) ack_bad <= 1'b1;
                if (core_cnt == 15) begin
                    core_cnt <= 0;
                    busy_cnt <= 6 + int'($urandom_range(0, 16));
                end else begin
                    core_cnt <= core_cnt + 1;
                end
            end else begin
                if (core_cnt != 0) gap_bad <= 1'b1;
                if (busy_cnt > 1) busy_cnt <= busy_cnt - 1;
                else if (busy_cnt == 1) begin
                    busy_cnt <= 0;
                    core_rdy <= 1'b1;
                end
            end
            if (bus.oDone) done_cnt <= done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: pad the byte string (0x80, zeros to 56 mod 64, 64-bit bit length).
    task automatic build_exp();
        logic [7:0]  pb[$];
        logic [63:0] bl;
        pb = msg_q;
        pb.push_back(8'h80);
        while ((pb.size() % 64) != 56) pb.push_back(8'h00);
        bl = 64'(msg_q.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) pb.push_back(bl[8*k +: 8]);
        exp_q.delete();
        for (int i = 0; i < pb.size(); i += 4) exp_q.push_back({pb[i], pb[i+1], pb[i+2], pb[i+3]});
    endtask

    task automatic rand_msg(input int n);
        msg_q.delete();
        for (int k = 0; k < n; k++) msg_q.push_back(8'($urandom));
    endtask

    // Host driver: big-endian words, garbage in the unused bytes of the last word.
    task automatic send_msg(input int gap_max);
        int n;
        int nw;
        int t;
        logic [31:0] w;
        n  = msg_q.size();
        nw = (n + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (4*i + b < n) w[31-8*b -: 8] = msg_q[4*i + b];
                else w[31-8*b -: 8] = 8'($urandom);
            end
            repeat ($urandom_range(0, gap_max)) begin
                @(negedge clk);
                bus.iValid = 1'b0;
            end
            @(negedge clk);
            bus.iValid     = 1'b1;
            bus.iStart     = (i == 0);
            bus.iDat       = w;
            bus.iLast      = (i == nw - 1);
            bus.iLastBytes = 2'(n % 4);
            t = 0;
            while (!bus.oAck && t < 400) begin
                @(negedge clk);
                t++;
            end
            chk("ack_wait", 64'(t < 400), 64'd1);
            if (t >= 400) break;
            @(posedge clk);
        end
        @(negedge clk);
        bus.iValid = 1'b0;
        bus.iStart = 1'b0;
        bus.iLast  = 1'b0;
    endtask

    task automatic finish_msg(input string tag, input int cbase, input int dbase);
        int t;
        t = 0;
        build_exp();
        while (done_cnt == dbase && t < 4000) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        chk({tag, "_done"}, 64'(done_cnt - dbase), 64'd1);
        chk({tag, "_nwords"}, 64'(cap_q.size() - cbase), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (cbase + i < cap_q.size()) begin
                chk($sformatf("%s_w%0d", tag, i), 64'(cap_q[cbase + i]), 64'(exp_q[i]));
                chk($sformatf("%s_init%0d", tag, i), 64'(cap_init_q[cbase + i]), 64'(i == 0));
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ack"},   64'(bus.oAck), 64'd0);
        chk({tag, "_dat"},   64'(bus.oCoreDat), 64'd0);
        chk({tag, "_valid"}, 64'(bus.oCoreValid), 64'd0);
        chk({tag, "_init"},  64'(bus.oCoreInitial), 64'd0);
        chk({tag, "_done"},  64'(bus.oDone), 64'd0);
`ifdef SHA1_PAD_CNT_EN
        chk({tag, "_blocks"}, 64'(bus.oBlocks), 64'd0);
`endif
    endtask

    initial begin
        int cb;
        int db;
        int t;
        bus.iValid = 1'b0; bus.iStart = 1'b0; bus.iDat = 32'h0;
        bus.iLast  = 1'b0; bus.iLastBytes = 2'd0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        @(negedge clk) rst = 1'b0;

        // A word without iStart while idle is dropped.
        @(negedge clk);
        bus.iValid = 1'b1; bus.iStart = 1'b0; bus.iLast = 1'b1; bus.iDat = 32'hDEAD_BEEF;
        t = 0;
        while (!bus.oAck && t < 50) begin @(negedge clk); t++; end
        @(posedge clk);
        @(negedge clk) bus.iValid = 1'b0; bus.iLast = 1'b0;

        // "abc": single block with spec-given constants as well.
        msg_q.delete(); msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
        cb = cap_q.size(); db = done_cnt;
        send_msg(0);
        finish_msg("abc", cb, db);
        chk("abc_w0_const",  64'(cap_q[cb]),      64'h6162_6380);
        chk("abc_w15_const", 64'(cap_q[cb + 15]), 64'h0000_0018);

        // 29-byte message ending in 0x21.
        rand_msg(28); msg_q.push_back(8'h21);
        cb = cap_q.size(); db = done_cnt;
        send_msg(1);
        finish_msg("m29", cb, db);
        chk("m29_w7_const", 64'(cap_q[cb + 7]), 64'h2180_0000);

        // 14 full words of 'a': pad word lands at index 14, length in a second block.
        msg_q.delete();
        for (int k = 0; k < 56; k++) msg_q.push_back(8'h61);
        cb = cap_q.size(); db = done_cnt;
        send_msg(0);
        finish_msg("m56", cb, db);

        // 17-word message: block sent on reaching 16 words.
        rand_msg(68);
        cb = cap_q.size(); db = done_cnt;
        send_msg(0);
        finish_msg("m68", cb, db);
`ifdef SHA1_PAD_CNT_EN
        chk("m68_blocks", 64'(bus.oBlocks), 64'd2);
`endif

        // Core held busy: nothing may be sent until ready rises.
        hold_rdy = 1'b1;
        rand_msg(8);
        cb = cap_q.size(); db = done_cnt;
        send_msg(0);
        repeat (40) @(posedge clk);
        chk("hold_nowords", 64'(cap_q.size() - cb), 64'd0);
        @(negedge clk) hold_rdy = 1'b0;
        finish_msg("hold", cb, db);
`ifdef SHA1_PAD_CNT_EN
        chk("hold_blocks", 64'(bus.oBlocks), 64'd1);
`endif

        // Reset in the middle of SEND, then a fresh message.
        rand_msg(20);
        cb = cap_q.size();
        send_msg(0);
        t = 0;
        while (cap_q.size() < cb + 5 && t < 200) begin @(posedge clk); t++; end
        chk("midsend_started", 64'(t < 200), 64'd1);
        #2 rst = 1'b1;
        #1 check_idle_outputs("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rand_msg(40);
        cb = cap_q.size(); db = done_cnt;
        send_msg(1);
        finish_msg("after_rst", cb, db);

        // Randomized messages, boundary lengths first.
        for (int m = 0; m < 10; m++) begin
            rand_msg((m < 6) ? lens[m] : int'($urandom_range(1, 200)));
            cb = cap_q.size(); db = done_cnt;
            send_msg(2);
            finish_msg($sformatf("rnd%0d_len%0d", m, msg_q.size()), cb, db);
        end

        chk("no_gap_in_block", 64'(gap_bad), 64'd0);
        chk("no_ack_while_sending", 64'(ack_bad), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
